// File: rtl/prog_readback.sv
// prog_readback: sweeps an instruction-memory address range and streams each word out with its address.
// Latency: one address cycle plus one present cycle per word; an N-word sweep pulses done 2N+1 cycles after start.
// Backpressure: the captured word holds stable on out_valid until out_ready; abort drops out_valid in the same cycle.
//
// Ports
//   clk, reset          block clock (shared with the instruction memory), async active-high reset
//   start, abort        sweep request (honoured only when idle) / sweep termination
//   first_addr,
//   last_addr           inclusive address range, sampled on an accepted start; wraps past 2^ADDR_WIDTH-1
//   mem_addr,
//   mem_rd_data         instruction-memory address (0 when idle) and its combinational read data
//   prog_enable         address-mux select, this block owns the memory address while high
//   hold_cpu_reset      keeps the CPU in reset for the whole sweep
//   out_valid/ready,
//   out_data/addr/last  streamed instruction words with their address and end-of-sweep marker
//   busy, done          sweep in progress / one-cycle completion pulse (also on abort)
//
// Optional feature: define PROG_READBACK_CHECKSUM_EN to add checksum and checksum_valid, a
// modulo-2^DATA_WIDTH sum of every transferred word, flagged valid in the DONE cycle of a sweep
// that was not aborted.

module prog_readback #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  prog_enable,
    output logic                  hold_cpu_reset,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
`ifdef PROG_READBACK_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  checksum_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] cur_nxt;
    logic [ADDR_WIDTH-1:0] last_r;
    logic [ADDR_WIDTH-1:0] last_nxt;
    logic                  active;
    logic                  handshake;
    logic                  capture;

    // ------------------------------------------------------------------
    // Status and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        active         = (state != IDLE);
        busy           = active;
        prog_enable    = active;
        hold_cpu_reset = active;
        // Drive a quiet address when the mux is not ours.
        mem_addr       = active ? cur : '0;
        // abort kills the offer combinationally so a same-cycle out_ready
        // can never complete a transfer the sequencer is throwing away.
        out_valid      = (state == SEND) && !abort;
        handshake      = out_valid && out_ready;
        done           = (state == DONE);
        capture        = (state == ADDR);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        last_nxt  = last_r;
        unique case (state)
            IDLE: begin
                // Range is sampled only here, so a start while busy leaves
                // the running sweep untouched.
                if (start) begin
                    cur_nxt   = first_addr;
                    last_nxt  = last_addr;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                state_nxt = abort ? DONE : SEND;
            end
            SEND: begin
                if (abort) begin
                    state_nxt = DONE;
                end else if (handshake) begin
                    if (out_last) begin
                        state_nxt = DONE;
                    end else begin
                        // Natural wrap at 2^ADDR_WIDTH gives the modulo step.
                        cur_nxt   = cur + 1'b1;
                        state_nxt = ADDR;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and sweep registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cur    <= '0;
            last_r <= '0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            last_r <= last_nxt;
        end
    end

    // Output word register: loaded at the end of the address cycle, then
    // held for the whole SEND phase regardless of out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else if (capture) begin
            out_data <= mem_rd_data;
            out_addr <= cur;
            out_last <= (cur == last_r);
        end
    end

`ifdef PROG_READBACK_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running checksum of transferred words
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] csum_r;
    logic                  aborted_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r    <= '0;
            aborted_r <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                csum_r    <= '0;
                aborted_r <= 1'b0;
            end else begin
                if (handshake) begin
                    csum_r <= csum_r + out_data;
                end
                // Remember that this sweep ended early so DONE does not
                // advertise a partial sum.
                if (abort && ((state == ADDR) || (state == SEND))) begin
                    aborted_r <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        checksum       = csum_r;
        checksum_valid = (state == DONE) && !aborted_r;
    end
`endif

endmodule

// File: tb/tb_prog_readback.sv
module tb_prog_readback;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic [3:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       prog_enable;
    logic       hold_cpu_reset;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [3:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef PROG_READBACK_CHECKSUM_EN
    logic [7:0] checksum;
    logic       checksum_valid;
`endif

    prog_readback #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .first_addr     (first_addr),
        .last_addr      (last_addr),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .prog_enable    (prog_enable),
        .hold_cpu_reset (hold_cpu_reset),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_addr       (out_addr),
        .out_last       (out_last),
        .busy           (busy),
`ifdef PROG_READBACK_CHECKSUM_EN
        .checksum       (checksum),
        .checksum_valid (checksum_valid),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    // Instruction memory with combinational read.
    logic [7:0] mem [16];
    assign mem_rd_data = mem[mem_addr];

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       l;
    } word_t;

    word_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    ready_mode = 0;   // 0: ready high, 1: random, 2: ready low
    logic [7:0] done_cs;
    logic       done_csv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the address sequence a sweep must produce.
    task automatic build(input logic [3:0] f, input logic [3:0] l);
        logic [3:0] a;
        word_t      w;
        a = f;
        for (int i = 0; i < 16; i++) begin
            w.a = a;
            w.d = mem[a];
            w.l = (a == l);
            exp_q.push_back(w);
            if (a == l) break;
            a = a + 4'd1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Compare process: every cycle checks protocol/stability, and pops the
    // model queue on each transfer.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [3:0] prev_addr;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_data_stable", {24'd0, out_data}, {24'd0, prev_data});
                chk("stall_addr_stable", {28'd0, out_addr}, {28'd0, prev_addr});
            end
            if (out_valid) begin
                chk("send_mem_addr", {28'd0, mem_addr}, {28'd0, out_addr});
                chk("send_flags", {29'd0, busy, prog_enable, hold_cpu_reset}, 32'd7);
            end
            if (!busy) begin
                chk("idle_outputs", {24'd0, mem_addr, out_valid, prog_enable, hold_cpu_reset, done}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {28'd0, out_addr}, 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_data", {24'd0, out_data}, {24'd0, w.d});
                    chk("word_addr", {28'd0, out_addr}, {28'd0, w.a});
                    chk("word_last", {31'd0, out_last}, {31'd0, w.l});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    task automatic start_sweep(input logic [3:0] f, input logic [3:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", {30'd0, busy, hold_cpu_reset}, 32'd3);
        chk("start_no_valid_yet", {31'd0, out_valid}, 32'd0);
    endtask

    // Counts cycles from the accepted start edge to the done pulse.
    task automatic wait_done(output int cyc, input int limit);
        cyc = 1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cyc >= limit) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
`ifdef PROG_READBACK_CHECKSUM_EN
        done_cs  = checksum;
        done_csv = checksum_valid;
`endif
        chk("hold_in_done", {31'd0, hold_cpu_reset}, 32'd1);
        @(posedge clk);
        #1;
        chk("after_done", {29'd0, hold_cpu_reset, busy, done}, 32'd0);
    endtask

    task automatic sweep(input logic [3:0] f, input logic [3:0] l, input int n_exp,
                         input int cyc_exp, input string tag);
        int cyc;
        build(f, l);
        chk({tag, "_model_len"}, exp_q.size(), n_exp);
        start_sweep(f, l);
        wait_done(cyc, 2000);
        if (cyc_exp > 0) chk({tag, "_cycles"}, cyc, cyc_exp);
        chk({tag, "_all_words_seen"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = 4'd0;
        last_addr  = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {26'd0, prog_enable, hold_cpu_reset, busy, out_valid, out_last, done}, 32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_out", {20'd0, out_data, out_addr}, 32'd0);
`ifdef PROG_READBACK_CHECKSUM_EN
        chk("rst_checksum", {23'd0, checksum, checksum_valid}, 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic 12-word sweep: done 2N+1 = 25 cycles after start.
        sweep(4'd0, 4'd11, 12, 25, "seq0_11");

        // Wrapping range, pin the model's address order.
        build(4'd14, 4'd1);
        chk("wrap_a0", {28'd0, exp_q[0].a}, 32'd14);
        chk("wrap_a1", {28'd0, exp_q[1].a}, 32'd15);
        chk("wrap_a2", {28'd0, exp_q[2].a}, 32'd0);
        chk("wrap_a3_last", {27'd0, exp_q[3].a, exp_q[3].l}, {27'd0, 4'd1, 1'b1});
        exp_q.delete();
        sweep(4'd14, 4'd1, 4, 9, "wrap");

        sweep(4'd5, 4'd5, 1, 3, "single");
        sweep(4'd6, 4'd5, 16, 33, "full");

        // Random backpressure.
        ready_mode = 1;
        sweep(4'd3, 4'd12, 10, -1, "rand_ready");
        ready_mode = 0;
        @(posedge clk);
        #1;

        // start while busy is ignored.
        fork
            sweep(4'd0, 4'd3, 4, 9, "start_busy");
            begin
                repeat (3) @(posedge clk);
                #1;
                first_addr = 4'd8;
                last_addr  = 4'd9;
                start      = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        // abort in IDLE has no effect.
        abort = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_idle", {30'd0, busy, done}, 32'd0);
        end
        abort = 1'b0;

        // abort in SEND together with out_ready.
        build(4'd0, 4'd7);
        start_sweep(4'd0, 4'd7);
        for (int i = 0; i < 40; i++) begin
            if (out_valid && out_addr == 4'd2) break;
            @(posedge clk);
            #1;
        end
        chk("abort_reached_send", {27'd0, out_valid, out_addr}, {27'd0, 1'b1, 4'd2});
        abort = 1'b1;
        #1;
        chk("abort_drops_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_done_pulse", {30'd0, done, hold_cpu_reset}, 32'd3);
`ifdef PROG_READBACK_CHECKSUM_EN
        chk("abort_no_csum_valid", {31'd0, checksum_valid}, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("abort_after", {29'd0, done, hold_cpu_reset, busy}, 32'd0);
        chk("abort_words_left", exp_q.size(), 6);
        exp_q.delete();

        // Reset while in SEND.
        ready_mode = 2;
        @(posedge clk);
        #1;
        build(4'd0, 4'd5);
        start_sweep(4'd0, 4'd5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("rst_mid_in_send", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_ctrl", {26'd0, prog_enable, hold_cpu_reset, busy, out_valid, out_last, done}, 32'd0);
        chk("rst_mid_data", {16'd0, out_data, out_addr, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_no_done", {30'd0, done, busy}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Recovery after reset.
        sweep(4'd2, 4'd4, 3, 7, "post_reset");

`ifdef PROG_READBACK_CHECKSUM_EN
        mem[0] = 8'h80;
        mem[1] = 8'h90;
        mem[2] = 8'h7F;
        sweep(4'd0, 4'd2, 3, 7, "csum");
        chk("csum_value", {24'd0, done_cs}, 32'h8F);
        chk("csum_valid_in_done", {31'd0, done_csv}, 32'd1);
        chk("csum_holds", {23'd0, checksum, checksum_valid}, {23'd0, 8'h8F, 1'b0});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
